atm_ledger_arbiter: RTL and testbench
=====================================

// Module: atm_ledger_arbiter
// PURPOSE
//   Owns the single account-balance register of the ATM and shares it between three
//   transaction requesters from the ATM FSM: deposit, withdraw and transfer-out.
//   Round-robin arbitration and a 4-phase req/done handshake serialise all updates.
//   Every update is checked for insufficient funds, the daily debit limit and
//   balance overflow before it commits.
// PARAMETERS
//   BAL_W         32          width of balance, amounts and daily-spent counter
//   INIT_BALANCE  32'd100000  balance loaded at reset
//   DAILY_LIMIT   32'd20000   maximum withdraw+transfer total per day
// PORTS
//   clk            in   1      clock; all logic on the rising edge
//   reset          in   1      asynchronous, active-low reset
//   req            in   3      [0]=deposit [1]=withdraw [2]=transfer; held high until done
//   dep_amount     in   BAL_W  deposit amount; sampled at grant
//   wd_amount      in   BAL_W  withdraw amount; sampled at grant
//   xfer_amount    in   BAL_W  transfer amount; sampled at grant
//   session_active in   1      new grants are allowed only while high
//   day_rollover   in   1      1-cycle pulse; clears spent_today
//   grant          out  3      one-hot winner; valid only while done=1
//   done           out  1      1-cycle completion pulse
//   status         out  2      00 ok, 01 insufficient funds, 10 limit exceeded, 11 overflow; valid with done
//   balance        out  BAL_W  current balance
//   spent_today    out  BAL_W  debits committed since the last rollover or reset
//   busy           out  1      high in every state except IDLE
// BEHAVIOUR
//   Reset values: grant=0, done=0, status=00, busy=0, balance=INIT_BALANCE,
//     spent_today=0, last_served=2 (so deposit has first priority), FSM=IDLE.
//   FSM states: IDLE -> CHECK -> COMMIT -> RESP -> WAIT_DROP -> IDLE.
//   IDLE
//     - Trigger: any req bit high and session_active=1.
//     - Winner: first set bit scanning from last_served+1, mod 3.
//     - Latch the winner index and its amount; update last_served; go to CHECK.
//   CHECK: compute the status code; always go to COMMIT.
//     - Deposit: a carry out of BAL_W+1-bit sum balance+amt gives status 11.
//     - Withdraw/transfer: amt > balance gives status 01.
//     - Otherwise, if spent_today+amt (BAL_W+1 bits) > DAILY_LIMIT, status 10.
//     - Otherwise status 00. Funds check has priority over the limit check.
//   COMMIT
//     - Writes only if status=00. Deposit: balance += amt.
//     - Withdraw/transfer: balance -= amt and spent_today += amt.
//   RESP: done=1, grant=one-hot winner, status driven, all for exactly one cycle.
//   WAIT_DROP: stay until req[winner]=0, then go to IDLE. One request never gets two services.
//   Latency: req sampled in IDLE at edge k gives done high in the cycle after edge k+3.
//     It is 3 cycles for every outcome, failures included.
//   amt=0 is legal: status 00, no state change, still a full handshake.
//   session_active falling mid-transaction: the current transaction completes normally.
//     It only blocks new grants from IDLE.
//   day_rollover in any state clears spent_today.
//     If it coincides with a debit COMMIT, spent_today ends equal to amt (clear, then add).
//   Amount inputs are ignored after the grant; changing them mid-transaction has no effect.
//   Reset mid-operation: every register is restored to its reset value at once.
//     No done is produced and a partial commit is impossible.
// TESTING
//   withdraw 5000 -> done 3 cycles after IDLE sample, grant=010, status=00, balance=95000, spent=5000
//   withdraw 150000 -> status=01; balance stays 100000; spent stays 0
//   withdraw 15000, then withdraw 6000 -> 2nd status=10, balance=85000, spent=15000
//     then day_rollover, retry 6000 -> status=00, balance=79000, spent=6000
//   req=111 held after reset, each dropped after its done -> grants 001, 010, 100 in order, three done pulses
//   deposit 32'hFFFFFFFF at balance 100000 -> status=11, balance unchanged
//   reset low during COMMIT of withdraw 5000 -> balance=100000, no done; req held with session_active=0 -> no grant

Source files
------------

// File: rtl/atm_ledger_arbiter.sv
// Account-balance owner for the ATM: round-robin arbitration between deposit, withdraw
// and transfer requesters, with funds, daily-limit and overflow checks before each commit.
module atm_ledger_arbiter #(
  parameter int unsigned      BAL_W        = 32,
  parameter logic [BAL_W-1:0] INIT_BALANCE = BAL_W'(100000),
  parameter logic [BAL_W-1:0] DAILY_LIMIT  = BAL_W'(20000)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [2:0]       req_i,
  input  logic [BAL_W-1:0] dep_amount_i,
  input  logic [BAL_W-1:0] wd_amount_i,
  input  logic [BAL_W-1:0] xfer_amount_i,
  input  logic             session_active_i,
  input  logic             day_rollover_i,
  output logic [2:0]       grant_o,
  output logic             done_o,
  output logic [1:0]       status_o,
  output logic [BAL_W-1:0] balance_o,
  output logic [BAL_W-1:0] spent_today_o,
  output logic             busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    COMMIT,
    RESP,
    WAIT_DROP
  } state_e;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_FUNDS = 2'b01;
  localparam logic [1:0] ST_LIMIT = 2'b10;
  localparam logic [1:0] ST_OVF   = 2'b11;

  localparam logic [1:0] IDX_DEP  = 2'd0;
  localparam logic [1:0] IDX_WD   = 2'd1;
  localparam logic [1:0] IDX_XFER = 2'd2;

  state_e           state_q, state_d;
  logic [1:0]       winner_q, winner_d;
  logic [1:0]       last_q, last_d;
  logic [BAL_W-1:0] amt_q, amt_d;
  logic [1:0]       chk_q, chk_d;
  logic [BAL_W-1:0] bal_q, bal_d;
  logic [BAL_W-1:0] spent_q, spent_d;
  logic [2:0]       grant_q, grant_d;
  logic             done_q, done_d;
  logic [1:0]       status_q, status_d;

  logic             pick_valid;
  logic [1:0]       pick_idx;
  logic [1:0]       cand;
  logic [BAL_W-1:0] pick_amt;
  logic [BAL_W:0]   dep_sum;
  logic [BAL_W:0]   debit_sum;
  logic [1:0]       chk_status;

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == IDX_XFER) ? IDX_DEP : idx + 2'd1;
  endfunction

  // Round-robin scan starting just after the last requester served.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = IDX_DEP;
    cand       = rr_next(last_q);
    for (int k = 0; k < 3; k++) begin
      if (!pick_valid && req_i[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
      cand = rr_next(cand);
    end
  end

  always_comb begin
    case (pick_idx)
      IDX_DEP: pick_amt = dep_amount_i;
      IDX_WD:  pick_amt = wd_amount_i;
      default: pick_amt = xfer_amount_i;
    endcase
  end

  // Funds shortfall outranks the daily-limit check for debits.
  always_comb begin
    dep_sum    = {1'b0, bal_q} + {1'b0, amt_q};
    debit_sum  = {1'b0, spent_q} + {1'b0, amt_q};
    chk_status = ST_OK;
    if (winner_q == IDX_DEP) begin
      if (dep_sum[BAL_W]) begin
        chk_status = ST_OVF;
      end
    end else if (amt_q > bal_q) begin
      chk_status = ST_FUNDS;
    end else if (debit_sum > {1'b0, DAILY_LIMIT}) begin
      chk_status = ST_LIMIT;
    end
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    last_d   = last_q;
    amt_d    = amt_q;
    chk_d    = chk_q;
    bal_d    = bal_q;
    spent_d  = spent_q;
    grant_d  = 3'b000;
    done_d   = 1'b0;
    status_d = ST_OK;

    // Rollover clears first so a same-cycle debit commit leaves spent equal to amt.
    if (day_rollover_i) begin
      spent_d = '0;
    end

    case (state_q)
      IDLE: begin
        if (pick_valid && session_active_i) begin
          winner_d = pick_idx;
          last_d   = pick_idx;
          amt_d    = pick_amt;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        chk_d   = chk_status;
        state_d = COMMIT;
      end
      COMMIT: begin
        if (chk_q == ST_OK) begin
          if (winner_q == IDX_DEP) begin
            bal_d = bal_q + amt_q;
          end else begin
            bal_d   = bal_q - amt_q;
            spent_d = spent_d + amt_q;
          end
        end
        state_d = RESP;
      end
      RESP: begin
        done_d   = 1'b1;
        grant_d  = 3'b001 << winner_q;
        status_d = chk_q;
        state_d  = WAIT_DROP;
      end
      WAIT_DROP: begin
        if (!req_i[winner_q]) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      winner_q <= IDX_DEP;
      last_q   <= IDX_XFER;
      amt_q    <= '0;
      chk_q    <= ST_OK;
      bal_q    <= INIT_BALANCE;
      spent_q  <= '0;
      grant_q  <= 3'b000;
      done_q   <= 1'b0;
      status_q <= ST_OK;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      last_q   <= last_d;
      amt_q    <= amt_d;
      chk_q    <= chk_d;
      bal_q    <= bal_d;
      spent_q  <= spent_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      status_q <= status_d;
    end
  end

  assign grant_o       = grant_q;
  assign done_o        = done_q;
  assign status_o      = status_q;
  assign balance_o     = bal_q;
  assign spent_today_o = spent_q;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_atm_ledger_arbiter.sv
// Scoreboard bench for atm_ledger_arbiter: a ledger model predicts each completion,
// a monitor pops and compares on every done pulse.
module tb_atm_ledger_arbiter;

  localparam longint INIT_BAL = 100000;
  localparam longint LIMIT    = 20000;
  localparam longint MAXV     = 64'h0000_0000_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rstN;
  logic [2:0]  req;
  logic [31:0] depAmt, wdAmt, xferAmt;
  logic        session, rollover;
  logic [2:0]  grantO;
  logic        doneO;
  logic [1:0]  statusO;
  logic [31:0] balanceO, spentO;
  logic        busyO;

  atm_ledger_arbiter dut (
    .clk_i            (clk),
    .rst_ni           (rstN),
    .req_i            (req),
    .dep_amount_i     (depAmt),
    .wd_amount_i      (wdAmt),
    .xfer_amount_i    (xferAmt),
    .session_active_i (session),
    .day_rollover_i   (rollover),
    .grant_o          (grantO),
    .done_o           (doneO),
    .status_o         (statusO),
    .balance_o        (balanceO),
    .spent_today_o    (spentO),
    .busy_o           (busyO)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  grant;
    logic [1:0]  status;
    logic [31:0] bal;
    logic [31:0] spent;
    int          dueCyc;
  } exp_t;

  exp_t   expQ[$];
  int     checks = 0;
  int     errors = 0;
  longint mBal, mSpent;
  int     mLast;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, want);
    end
  endtask

  // Ledger rules straight from the account semantics, in 64-bit arithmetic.
  function automatic exp_t modelTxn(input int kind, input longint amt);
    exp_t e;
    e.grant  = 3'(1 << kind);
    e.status = 2'b00;
    if (kind == 0) begin
      if (mBal + amt > MAXV) e.status = 2'b11;
      else mBal = mBal + amt;
    end else if (amt > mBal) begin
      e.status = 2'b01;
    end else if (mSpent + amt > LIMIT) begin
      e.status = 2'b10;
    end else begin
      mBal   = mBal - amt;
      mSpent = mSpent + amt;
    end
    mLast   = kind;
    e.bal   = mBal[31:0];
    e.spent = mSpent[31:0];
    e.dueCyc = -1;
    return e;
  endfunction

  function automatic int modelPick(input logic [2:0] pending, input int last);
    for (int off = 1; off <= 3; off++) begin
      int idx;
      idx = (last + off) % 3;
      if (pending[idx]) return idx;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rstN === 1'b1) begin
      if (doneO === 1'b1) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedDone actual=grant %b status %b required=no done", grantO, statusO);
        end else begin
          e = expQ.pop_front();
          checkOutput("grant", 64'(grantO), 64'(e.grant));
          checkOutput("status", 64'(statusO), 64'(e.status));
          checkOutput("balance", 64'(balanceO), 64'(e.bal));
          checkOutput("spent", 64'(spentO), 64'(e.spent));
          if (e.dueCyc >= 0) checkOutput("latency", 64'(cyc), 64'(e.dueCyc));
        end
      end else begin
        checkOutput("grantWithoutDone", 64'(grantO), 64'd0);
      end
    end
  end

  task automatic setAmount(input int kind, input logic [31:0] amt);
    case (kind)
      0: depAmt = amt;
      1: wdAmt = amt;
      default: xferAmt = amt;
    endcase
  endtask

  task automatic waitDone(input string name, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (doneO === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput(name, 64'd0, 64'd1);
  endtask

  task automatic doReset();
    @(negedge clk);
    rstN = 1'b0;
    req = 3'b000;
    session = 1'b1;
    rollover = 1'b0;
    mBal = INIT_BAL;
    mSpent = 0;
    mLast = 2;
    expQ.delete();
    repeat (2) @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic pulseRollover();
    @(negedge clk);
    rollover = 1'b1;
    @(negedge clk);
    rollover = 1'b0;
    mSpent = 0;
  endtask

  // flags: bit0 scramble amounts after grant, bit1 drop session mid-flight, bit2 rollover at commit
  task automatic applyStimulus(input int kind, input logic [31:0] amt, input int flags);
    exp_t   e;
    longint a;
    bit     ok;
    @(negedge clk);
    setAmount(kind, amt);
    a = longint'(amt);
    e = modelTxn(kind, a);
    if (flags[2]) begin
      mSpent = (kind != 0 && e.status == 2'b00) ? a : 0;
      e.spent = mSpent[31:0];
    end
    e.dueCyc = cyc + 4;
    expQ.push_back(e);
    req[kind] = 1'b1;
    ok = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1 && flags[0]) begin
        depAmt = $urandom;
        wdAmt = $urandom;
        xferAmt = $urandom;
      end
      if (n == 1 && flags[1]) session = 1'b0;
      if (n == 2 && flags[2]) rollover = 1'b1;
      if (n == 3) rollover = 1'b0;
      if (doneO === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("doneTimeout", 64'd0, 64'd1);
    req = 3'b000;
    session = 1'b1;
    rollover = 1'b0;
    @(negedge clk);
  endtask

  task automatic roundRobinTest();
    logic [2:0] pending;
    int         order[3];
    exp_t       e;
    bit         ok;
    @(negedge clk);
    depAmt = 32'd100;
    wdAmt = 32'd200;
    xferAmt = 32'd300;
    pending = 3'b111;
    for (int s = 0; s < 3; s++) begin
      order[s] = modelPick(pending, mLast);
      e = modelTxn(order[s], (order[s] + 1) * 100);
      if (s == 0) e.dueCyc = cyc + 4;
      expQ.push_back(e);
      pending[order[s]] = 1'b0;
    end
    req = 3'b111;
    for (int s = 0; s < 3; s++) begin
      waitDone("rrDoneTimeout", ok);
      req[order[s]] = 1'b0;
    end
    @(negedge clk);
    checkOutput("rrOrder", 64'({order[0][1:0], order[1][1:0], order[2][1:0]}), 64'(6'b00_01_10));
  endtask

  task automatic midResetTest();
    exp_t e;
    bit   ok;
    @(negedge clk);
    wdAmt = 32'd5000;
    req = 3'b010;
    repeat (2) @(negedge clk);
    rstN = 1'b0;
    session = 1'b0;
    mBal = INIT_BAL;
    mSpent = 0;
    mLast = 2;
    @(negedge clk);
    checkOutput("rstDone", 64'(doneO), 64'd0);
    checkOutput("rstBalance", 64'(balanceO), 64'd100000);
    checkOutput("rstSpent", 64'(spentO), 64'd0);
    checkOutput("rstBusy", 64'(busyO), 64'd0);
    @(negedge clk);
    rstN = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("noSessionBusy", 64'(busyO), 64'd0);
    checkOutput("noSessionBalance", 64'(balanceO), 64'd100000);
    e = modelTxn(1, 5000);
    e.dueCyc = cyc + 4;
    expQ.push_back(e);
    session = 1'b1;
    waitDone("resumeDoneTimeout", ok);
    req = 3'b000;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] amt;
    int          kind;
    rstN = 1'b0;
    req = 3'b000;
    depAmt = '0;
    wdAmt = '0;
    xferAmt = '0;
    session = 1'b1;
    rollover = 1'b0;

    doReset();
    @(negedge clk);
    checkOutput("rstGrant", 64'(grantO), 64'd0);
    checkOutput("rstDoneInit", 64'(doneO), 64'd0);
    checkOutput("rstStatus", 64'(statusO), 64'd0);
    checkOutput("rstBusyInit", 64'(busyO), 64'd0);
    checkOutput("rstBalanceInit", 64'(balanceO), 64'd100000);
    checkOutput("rstSpentInit", 64'(spentO), 64'd0);

    applyStimulus(1, 32'd5000, 1);
    checkOutput("wd5000Balance", 64'(balanceO), 64'd95000);

    doReset();
    applyStimulus(1, 32'd150000, 0);
    checkOutput("wdTooMuchBalance", 64'(balanceO), 64'd100000);

    doReset();
    applyStimulus(1, 32'd15000, 0);
    applyStimulus(1, 32'd6000, 0);
    checkOutput("limitBalance", 64'(balanceO), 64'd85000);
    pulseRollover();
    applyStimulus(1, 32'd6000, 0);
    checkOutput("afterRolloverBalance", 64'(balanceO), 64'd79000);
    checkOutput("afterRolloverSpent", 64'(spentO), 64'd6000);

    doReset();
    roundRobinTest();

    doReset();
    applyStimulus(0, 32'hFFFF_FFFF, 0);
    checkOutput("overflowBalance", 64'(balanceO), 64'd100000);
    applyStimulus(0, 32'd0, 0);
    applyStimulus(2, 32'd0, 0);
    applyStimulus(2, 32'd3000, 2);
    applyStimulus(1, 32'd4000, 4);
    checkOutput("rolloverAtCommitSpent", 64'(spentO), 64'd4000);

    doReset();
    midResetTest();

    for (int i = 0; i < 150; i++) begin
      kind = int'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) amt = $urandom;
      else if (kind == 0) amt = $urandom_range(0, 30000);
      else amt = $urandom_range(0, 9000);
      if ($urandom_range(0, 9) == 0) amt = 32'd0;
      applyStimulus(kind, amt, int'($urandom_range(0, 7)));
      if ($urandom_range(0, 5) == 0) pulseRollover();
    end

    repeat (4) @(negedge clk);
    checkOutput("queueEmpty", 64'(expQ.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
